// File: rtl/mult_seq_if.sv
// Bundles the multiplier's request, result and shared-adder signals.
// The slave modport is the multiplier. The master modport is its user,
// which also owns the shared 32-bit adder.
interface mult_seq_if;
  logic        start;
  logic        is_signed;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_sub;
  logic [31:0] add_sum;
  logic        add_cout;

  modport slave (
    input  start, is_signed, src_a, src_b, add_sum, add_cout,
    output busy, done, hi, lo, add_a, add_b, add_sub
  );

  modport master (
    output start, is_signed, src_a, src_b, add_sum, add_cout,
    input  busy, done, hi, lo, add_a, add_b, add_sub
  );
endinterface

// File: rtl/mult_seq.sv
// Sequential 32x32 -> 64 shift-and-add multiplier (MULT/MULTU).
// It borrows one external 32-bit adder. Signed operands are first turned
// into magnitudes, then 32 unsigned add/shift steps run, and the 64-bit
// product is negated at the end if the signs differed.
// The latency is fixed: start is sampled on edge 1, and done is high after edge 37.
module mult_seq (
  input  logic        clk,
  input  logic        rst,
  mult_seq_if.slave   m
);

  typedef enum logic [2:0] {
    S_IDLE, S_ABS_A, S_ABS_B, S_MUL, S_NEG_LO, S_NEG_HI, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] a_q, b_q;       // operands, replaced by their magnitudes
  logic [31:0] p_hi, p_lo;     // running product; p_lo starts as the multiplier
  logic [4:0]  cnt;
  logic        sgn_q;          // signed mode latched with start
  logic        a_sgn;          // original sign of A, kept before A is replaced by |A|
  logic        neg_q;          // product must be negated
  logic        c_q;            // carry out of the low-word negate (low word was zero)
  logic [31:0] hi_q, lo_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (m.start) state_nxt = S_ABS_A;
      S_ABS_A:  state_nxt = S_ABS_B;
      S_ABS_B:  state_nxt = S_MUL;
      S_MUL:    if (cnt == 5'd31) state_nxt = S_NEG_LO;
      S_NEG_LO: state_nxt = S_NEG_HI;
      S_NEG_HI: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs: status flags and the adder operand mux
  always_comb begin
    m.busy    = (state != S_IDLE);
    m.done    = (state == S_DONE);
    m.add_a   = 32'd0;
    m.add_b   = 32'd0;
    m.add_sub = 1'b0;
    case (state)
      S_ABS_A:  begin m.add_b = a_q;  m.add_sub = 1'b1; end
      S_ABS_B:  begin m.add_b = b_q;  m.add_sub = 1'b1; end
      S_MUL:    begin
        m.add_a = p_hi;
        m.add_b = p_lo[0] ? a_q : 32'd0;
      end
      S_NEG_LO: begin m.add_b = p_lo; m.add_sub = 1'b1; end
      S_NEG_HI: if (neg_q && c_q) begin m.add_b = p_hi; m.add_sub = 1'b1; end
      default:  ;
    endcase
  end

  // Datapath: operand capture, magnitudes, add/shift steps, final negate
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; p_hi <= '0; p_lo <= '0; cnt <= '0;
      sgn_q <= 1'b0; a_sgn <= 1'b0; neg_q <= 1'b0; c_q <= 1'b0;
      hi_q <= '0; lo_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (m.start) begin
          a_q   <= m.src_a;
          b_q   <= m.src_b;
          sgn_q <= m.is_signed;
          a_sgn <= m.src_a[31];
          cnt   <= '0;
          p_hi  <= '0;
        end
        S_ABS_A: if (sgn_q && a_q[31]) a_q <= m.add_sum;
        S_ABS_B: begin
          if (sgn_q && b_q[31]) begin
            b_q  <= m.add_sum;
            p_lo <= m.add_sum;
          end else begin
            p_lo <= b_q;
          end
          neg_q <= sgn_q & (a_sgn ^ b_q[31]);
        end
        S_MUL: begin
          // {cout, sum, p_lo} shifted right by one bit; the bit shifted out at the bottom is dropped
          p_hi <= {m.add_cout, m.add_sum[31:1]};
          p_lo <= {m.add_sum[0], p_lo[31:1]};
          cnt  <= cnt + 5'd1;
        end
        S_NEG_LO: if (neg_q) begin
          p_lo <= m.add_sum;
          c_q  <= m.add_cout;
        end
        S_NEG_HI: begin
          // The result registers are loaded on the way into DONE, so hi/lo
          // change only once per operation.
          if (neg_q) begin
            p_hi <= c_q ? m.add_sum : ~p_hi;
            hi_q <= c_q ? m.add_sum : ~p_hi;
          end else begin
            hi_q <= p_hi;
          end
          lo_q <= p_lo;
        end
        default: ;
      endcase
    end
  end

  assign m.hi = hi_q;
  assign m.lo = lo_q;

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 mult_seq SHALL have no parameters; all datapath widths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a multiply; SHALL be sampled only in IDLE.
REQ-005 is_signed  input  1  1 = two's-complement MULT, 0 = MULTU; SHALL be captured with start.
REQ-006 src_a, src_b  input  32 each  operands; SHALL be captured with start.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse when hi/lo become valid.
REQ-009 hi, lo  output  32 each  upper and lower words of the 64-bit product.
REQ-010 add_a, add_b  output  32 each  operands driven to the shared 32-bit adder.
REQ-011 add_sub  output  1  adder mode: 0 = a+b, 1 = a+~b+1.
REQ-012 add_sum  input  32  adder result, combinational from add_a/add_b/add_sub.
REQ-013 add_cout  input  1  adder carry out of bit 31.

Function
REQ-014 States SHALL be IDLE, ABS_A, ABS_B, MUL, NEG_LO, NEG_HI, DONE; each state except MUL and IDLE SHALL last exactly one cycle.
REQ-015 IDLE: start=1 SHALL capture operands and mode, clear iteration counter, set P_hi=0, -> ABS_A; start=0 stays IDLE.
REQ-016 ABS_A: drive add_a=0, add_b=A, add_sub=1; if is_signed and A[31], A <= add_sum, else A unchanged; -> ABS_B.
REQ-017 ABS_B: same as ABS_A for B; P_lo <= |B| (or B unsigned); record neg = is_signed & (A[31]^B[31]) using captured originals; -> MUL.
REQ-018 MUL: drive add_a=P_hi, add_b=(P_lo[0] ? |A| : 0), add_sub=0; {P_hi,P_lo} <= {add_cout, add_sum, P_lo} >> 1 (33+32 bits shifted right one, LSB discarded).
REQ-019 MUL SHALL run exactly 32 cycles (5-bit counter, 0..31); after count 31, -> NEG_LO.
REQ-020 NEG_LO: drive add_a=0, add_b=P_lo, add_sub=1; if neg, P_lo <= add_sum and store c=add_cout (1 iff P_lo==0); -> NEG_HI.
REQ-021 NEG_HI: if neg and c=1, drive add_a=0, add_b=P_hi, add_sub=1, P_hi <= add_sum; if neg and c=0, P_hi <= ~P_hi; if not neg, unchanged; -> DONE.
REQ-022 DONE: hi <= P_hi, lo <= P_lo on entry; done=1 for this single cycle; -> IDLE.
REQ-023 Latency SHALL be fixed: done high exactly 37 cycles after the edge sampling start, for both modes and all operand values.
REQ-024 In IDLE and DONE the adder outputs SHALL be driven add_a=0, add_b=0, add_sub=0.
REQ-025 start asserted while busy SHALL be ignored, with no effect on the operation in flight.
REQ-026 start may be asserted in the cycle after done; it SHALL be accepted (back-to-back issue).
REQ-027 hi/lo SHALL hold their last value until the next DONE, and SHALL not change in intermediate states.
REQ-028 Zero operands and the most-negative value 0x80000000 SHALL give exact 64-bit products (magnitude 2^31 held unsigned).

Reset
REQ-029 rst=1 at a rising edge SHALL force state IDLE, busy=0, done=0, hi=0, lo=0, and clear the counter, P_hi, P_lo, neg and c.
REQ-030 rst SHALL override any state, including mid-MUL; start in the same cycle as rst SHALL be ignored.
REQ-031 After rst deasserts, the first start SHALL behave exactly as from a clean power-up.

Verification
REQ-032 Unsigned: a=7, b=6, is_signed=0 -> done at +37 cycles, hi=0x00000000, lo=0x0000002A.
REQ-033 Unsigned: a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 Signed: a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; a=b=0xFFFFFFFF -> hi=0, lo=1.
REQ-035 Signed: a=b=0x80000000 -> hi=0x40000000, lo=0x00000000; a=0, b=0x80000000 -> hi=lo=0.
REQ-036 Drive start every cycle during an operation -> only the first start is accepted, and exactly one done pulse appears per accepted start.
REQ-037 Assert rst at MUL iteration 10 -> next cycle IDLE with busy=0, hi=lo=0; a following start with 7*6 gives 0x2A after 37 cycles.
